// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word, RAM handshake state and the arbiter grant state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_picker.sv
// Next-grant selection: data wins unless fetch has been starved STARVE_MAX times.
module arb_picker
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int SW         = 3
) (
   input  logic          iREN,
   input  logic          dREN,
   input  logic          dWEN,
   input  logic [SW-1:0] starve_cnt,
   output arb_state_t    pick
);

   // pick the requester to grant from IDLE
   always_comb begin
      pick = IDLE;
      if ((dREN | dWEN) && ((starve_cnt < SW'(STARVE_MAX)) || !iREN))
         pick = GNT_D;
      else if (iREN)
         pick = GNT_I;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Grants are registered and held until ACCESS, ERROR, timeout or withdrawal.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      busy,
   output logic      err
);

   localparam int TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
   localparam int SW = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);

   arb_state_t    state, state_n, pick;
   logic [SW-1:0] starve_cnt, starve_n;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic          err_n;
   logic          i_done, d_done;
   logic          g_act;

   arb_picker #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_picker (
      .iREN       (iREN),
      .dREN       (dREN),
      .dWEN       (dWEN),
      .starve_cnt (starve_cnt),
      .pick       (pick)
   );

   // granted requester still asking for the port
   assign g_act = (state == GNT_I) ? iREN : (dREN | dWEN);

   // next state, counters, completion and error detection
   always_comb begin
      state_n  = state;
      starve_n = starve_cnt;
      tmo_n    = tmo_cnt;
      err_n    = 1'b0;
      i_done   = 1'b0;
      d_done   = 1'b0;
      case (state)
         IDLE: begin
            state_n = pick;
            tmo_n   = '0;
            if (pick == GNT_D) begin
               err_n = dREN & dWEN;
               if (!iREN)
                  starve_n = '0;
               else if (starve_cnt != SW'(STARVE_MAX))
                  starve_n = starve_cnt + SW'(1);
            end else if (pick == GNT_I) begin
               starve_n = '0;
            end
         end
         GNT_I, GNT_D: begin
            if (!g_act) begin
               state_n = IDLE;
            end else if (ramstate == ACCESS) begin
               state_n = IDLE;
               i_done  = (state == GNT_I);
               d_done  = (state == GNT_D);
            end else if (ramstate == ERROR || tmo_cnt == TW'(TIMEOUT)) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end else begin
               tmo_n = tmo_cnt + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state and counter registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_n;
         tmo_cnt    <= tmo_n;
         err        <= err_n;
      end
   end

   // RAM port driven from the live inputs of the granted requester
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state)
         GNT_I: begin
            ramREN  = iREN;
            ramaddr = iaddr;
         end
         GNT_D: begin
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         default: ;
      endcase
   end

   assign iwait = ~i_done;
   assign dwait = ~d_done;
   assign iload = i_done ? ramload : '0;
   assign dload = d_done ? ramload : '0;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam logic [31:0] IADDR  = 32'h0000_0040;
   localparam logic [31:0] DADDR  = 32'h0000_0100;
   localparam logic [31:0] DSTORE = 32'hDEAD_BEEF;
   localparam logic [31:0] RLOAD  = 32'h1234_5678;
   localparam int          TMO    = 8;

   logic      CLK, nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   logic      iwait, dwait, ramREN, ramWEN, busy, err;
   word_t     iload, dload, ramaddr, ramstore;
   ramstate_t ramstate;

   int pass_cnt = 0;
   int total    = 0;

   mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .busy(busy), .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, ".ramREN"},   32'(ramREN),  0);
      chk({pfx, ".ramWEN"},   32'(ramWEN),  0);
      chk({pfx, ".ramaddr"},  ramaddr,      0);
      chk({pfx, ".ramstore"}, ramstore,     0);
      chk({pfx, ".iwait"},    32'(iwait),   1);
      chk({pfx, ".dwait"},    32'(dwait),   1);
      chk({pfx, ".iload"},    iload,        0);
      chk({pfx, ".dload"},    dload,        0);
      chk({pfx, ".busy"},     32'(busy),    0);
      chk({pfx, ".err"},      32'(err),     0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   typedef struct {
      logic      i, d, w;
      ramstate_t rs;
      logic      rren, rwen;
      word_t     addr, store;
      logic      iw, dw, bsy, er;
   } vec_t;

   vec_t tv [14];

   initial begin
      int   gcyc, ng, n, errs, dw_low;
      logic seq [10];
      logic exp_seq [10];

      // row: i d w ramstate | ramREN ramWEN ramaddr ramstore iwait dwait busy err
      tv[0]  = '{1,0,0,FREE,   0,0,0,    0,     1,1,0,0};
      tv[1]  = '{1,0,0,ACCESS, 1,0,IADDR,0,     0,1,1,0};
      tv[2]  = '{0,1,0,FREE,   0,0,0,    0,     1,1,0,0};
      tv[3]  = '{0,1,0,BUSY,   1,0,DADDR,DSTORE,1,1,1,0};
      tv[4]  = '{0,1,0,ACCESS, 1,0,DADDR,DSTORE,1,0,1,0};
      tv[5]  = '{0,1,1,FREE,   0,0,0,    0,     1,1,0,0};
      tv[6]  = '{0,1,1,ACCESS, 0,1,DADDR,DSTORE,1,0,1,1};
      tv[7]  = '{0,0,0,FREE,   0,0,0,    0,     1,1,0,0};
      tv[8]  = '{0,0,1,FREE,   0,0,0,    0,     1,1,0,0};
      tv[9]  = '{0,0,1,ERROR,  0,1,DADDR,DSTORE,1,1,1,0};
      tv[10] = '{0,0,0,FREE,   0,0,0,    0,     1,1,0,1};
      tv[11] = '{1,0,0,FREE,   0,0,0,    0,     1,1,0,0};
      tv[12] = '{0,0,0,BUSY,   0,0,IADDR,0,     1,1,1,0};
      tv[13] = '{0,0,0,FREE,   0,0,0,    0,     1,1,0,0};

      iaddr = IADDR; daddr = DADDR; dstore = DSTORE; ramload = RLOAD;
      iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
      nRST = 1'b0;
      #2;
      chk_reset("rst");
      @(negedge CLK);
      nRST = 1'b1;

      // per-cycle vector table
      for (int k = 0; k < 14; k++) begin
         @(negedge CLK);
         iREN = tv[k].i; dREN = tv[k].d; dWEN = tv[k].w; ramstate = tv[k].rs;
         #1;
         chk($sformatf("v%0d.ramREN", k),   32'(ramREN), 32'(tv[k].rren));
         chk($sformatf("v%0d.ramWEN", k),   32'(ramWEN), 32'(tv[k].rwen));
         chk($sformatf("v%0d.ramaddr", k),  ramaddr,     tv[k].addr);
         chk($sformatf("v%0d.ramstore", k), ramstore,    tv[k].store);
         chk($sformatf("v%0d.iwait", k),    32'(iwait),  32'(tv[k].iw));
         chk($sformatf("v%0d.dwait", k),    32'(dwait),  32'(tv[k].dw));
         chk($sformatf("v%0d.iload", k),    iload,       tv[k].iw ? 32'h0 : RLOAD);
         chk($sformatf("v%0d.dload", k),    dload,       tv[k].dw ? 32'h0 : RLOAD);
         chk($sformatf("v%0d.busy", k),     32'(busy),   32'(tv[k].bsy));
         chk($sformatf("v%0d.err", k),      32'(err),    32'(tv[k].er));
      end

      // starvation: both held, 2-cycle RAM accesses -> D,D,D,D,I,D,D,D,D,I
      do_reset();
      exp_seq = '{0,0,0,0,1,0,0,0,0,1};
      iREN = 1; dREN = 1;
      gcyc = 0; ng = 0;
      for (int c = 0; c < 100 && ng < 10; c++) begin
         @(negedge CLK);
         #1;
         if (busy) begin
            gcyc++;
            if (gcyc == 1) begin
               seq[ng] = (ramaddr == IADDR);
               ramstate = BUSY;
            end else begin
               ramstate = ACCESS;
               #1;
               chk($sformatf("starve.iwait%0d", ng), 32'(iwait), exp_seq[ng] ? 32'd0 : 32'd1);
               ng++;
            end
         end else begin
            gcyc = 0;
            ramstate = FREE;
         end
      end
      chk("starve.ngrants", 32'(ng), 10);
      for (int k = 0; k < 10; k++)
         if (k < ng) chk($sformatf("starve.grant%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
      iREN = 0; dREN = 0; ramstate = FREE;

      // write held through 3 BUSY cycles then ACCESS
      do_reset();
      dWEN = 1;
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
         ramstate = (k == 3) ? ACCESS : BUSY;
         #1;
         chk($sformatf("wr%0d.ramWEN", k),   32'(ramWEN), 1);
         chk($sformatf("wr%0d.ramaddr", k),  ramaddr,     DADDR);
         chk($sformatf("wr%0d.ramstore", k), ramstore,    DSTORE);
         chk($sformatf("wr%0d.dwait", k),    32'(dwait),  (k == 3) ? 32'd0 : 32'd1);
         @(negedge CLK);
      end
      dWEN = 0; ramstate = FREE;
      #1;
      chk("wr.busy_after", 32'(busy), 0);
      chk("wr.err_after",  32'(err),  0);

      // timeout: RAM stuck BUSY
      do_reset();
      dREN = 1; ramstate = BUSY;
      n = 0; errs = 0; dw_low = 0;
      @(negedge CLK);
      #1;
      while (busy && n < 40) begin
         n++;
         if (!dwait) dw_low++;
         if (err) errs++;
         @(negedge CLK);
         #1;
      end
      chk("tmo.grant_cycles", 32'(n), TMO + 1);
      chk("tmo.dwait_low",    32'(dw_low), 0);
      chk("tmo.err_in_grant", 32'(errs), 0);
      chk("tmo.err_pulse",    32'(err), 1);
      chk("tmo.busy",         32'(busy), 0);
      @(negedge CLK);
      ramstate = ERROR;
      #1;
      chk("tmo.regrant",      32'(busy), 1);
      chk("tmo.err_single",   32'(err), 0);
      // same response from ERROR: abort right away
      chk("errst.dwait",      32'(dwait), 1);
      @(negedge CLK);
      ramstate = FREE;
      dREN = 0;
      #1;
      chk("errst.err_pulse",  32'(err), 1);
      chk("errst.busy",       32'(busy), 0);
      @(negedge CLK);
      #1;
      chk("errst.err_single", 32'(err), 0);

      // asynchronous reset during GNT_D drops the access
      do_reset();
      dWEN = 1; ramstate = BUSY;
      @(negedge CLK);
      #1;
      chk("arst.pre_busy",   32'(busy), 1);
      chk("arst.pre_ramWEN", 32'(ramWEN), 1);
      #2;
      nRST = 1'b0;
      #1;
      chk_reset("arst");
      dWEN = 0; ramstate = FREE;
      @(negedge CLK);
      nRST = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single RAM port between the pipelined datapath's instruction-fetch and data-access requests. It sits between the datapath/cache side and the RAM model. Grants are registered and held until the RAM reports ACCESS, ERROR, or a timeout. Data requests have priority, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending.
- TIMEOUT, 255: cycles a grant may wait for ACCESS before it is aborted.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address (word_t).
- iwait  out  1  low for exactly the cycle iload is valid.
- iload  out  32  instruction returned from RAM.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the cycle the data access completes.
- dload  out  32  read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- busy  out  1  a grant is active (state is not IDLE).
- err  out  1  one-cycle pulse on RAM ERROR, timeout, or a dREN and dWEN conflict.

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE: no RAM enables are driven. Arbitration order:
  - If dREN or dWEN is set and the starvation counter is below STARVE_MAX (or iREN is clear), go to GNT_D.
  - Otherwise, if iREN is set, go to GNT_I.
- GNT_I: ramREN = iREN, ramaddr = iaddr.
- GNT_D: ramREN = dREN & !dWEN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
- The RAM address and data are driven combinationally from the granted requester's live inputs. Requesters hold address and data stable while their wait signal is high.
- Completion: in GNT_x with ramstate == ACCESS, the matching wait is driven low that same cycle and iload/dload = ramload. The next state is IDLE.
- Withdrawal: if the granted requester's enables are all low in GNT_x, the next state is IDLE. No err pulse, no completion.
- ERROR, or the timeout counter reaching TIMEOUT in GNT_x: err pulses, the next state is IDLE, and wait stays high. The requester is re-arbitrated later.
- dREN and dWEN both high: treated as a write, and err pulses in the IDLE→GNT_D cycle.
- Starvation counter:
  - Increments on every IDLE→GNT_D transition taken while iREN is high, saturating at STARVE_MAX.
  - Clears on IDLE→GNT_I, and on IDLE→GNT_D taken while iREN is low.
- Timeout counter: 8+ bits wide (clog2(TIMEOUT+1)). Clears on entry to GNT_x and increments each GNT_x cycle without ACCESS.
- The wait of the non-granted requester is always high.

## Timing
- Reset values: state IDLE, both counters 0, ramREN/ramWEN 0, ramaddr/ramstore 0, iwait/dwait 1, iload/dload 0, busy 0, err 0.
- Reset asserted mid-grant: everything returns to reset values immediately; the in-flight access is dropped.
- Minimum latency: request seen in IDLE at cycle 0, grant in cycle 1, wait low in cycle 1 if the RAM returns ACCESS immediately, IDLE in cycle 2.
- Back-to-back accesses therefore take at least 2 cycles each; there is always one IDLE cycle between grants.
- err is registered and asserted in the cycle after the triggering event. Its width is exactly 1 cycle.
- iload/dload are combinational from ramload and are valid only while the matching wait is low.

## Structure
- Add arb_state_t (IDLE, GNT_I, GNT_D) to cpu_types_pkg beside ramstate_t. Reuse word_t and ramstate_t from that package.
- One natural sub-module, arb_picker: the combinational next-grant selection from the request inputs and the starvation counter. The FSM and counters stay in mem_arbiter.

## Test plan
- iREN=1, iaddr=0x40, RAM returns ACCESS on the first grant cycle → ramREN=1 and ramaddr=0x40 in cycle 1; iwait=0 and iload=ramload in cycle 1; busy=0 in cycle 2.
- iREN and dREN both held, each RAM access taking 2 cycles → grant sequence D,D,D,D,I,D,D,D,D,I; iwait goes low in the 5th grant.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, RAM BUSY for 3 cycles then ACCESS → ramWEN held 4 cycles with stable address and data; dwait low only in the ACCESS cycle.
- RAM stays BUSY with TIMEOUT=8 → err pulses once, the FSM returns to IDLE, dwait stays 1, and the request is re-granted afterwards. Repeat with ramstate=ERROR and check the same response.
- dREN and dWEN set together → write issued, err pulse. Separately, drop iREN mid-grant → return to IDLE with no err; then assert nRST low during GNT_D → all outputs return to reset values asynchronously.
